mac_seq: RTL

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_seq_fifo.sv | 50 +++++
 rtl/mac_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the mac_seq sequencer.
package mac_pkg;

  localparam int unsigned BW       = 4;
  localparam int unsigned PSUM_BW  = 16;
  localparam int unsigned NumLanes = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; Depth must be a power of two (>= 2).
module mac_seq_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AddrW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AddrW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_seq.sv
// Sequences 4-lane groups from an input FIFO through an external MAC and accumulates results.
// Optional MAC_SEQ_RELU_EN: clamp negative results to zero on out_data.
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned BW         = mac_pkg::BW,
  parameter int unsigned PSUM_BW    = mac_pkg::PSUM_BW,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAC_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LEN_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NumLanes*BW-1:0] in_a,
  input  logic [NumLanes*BW-1:0] in_b,
  output logic [BW-1:0]          a0,
  output logic [BW-1:0]          a1,
  output logic [BW-1:0]          a2,
  output logic [BW-1:0]          a3,
  output logic [BW-1:0]          b0,
  output logic [BW-1:0]          b1,
  output logic [BW-1:0]          b2,
  output logic [BW-1:0]          b3,
  output logic [PSUM_BW-1:0]     mac_c,
  input  logic [PSUM_BW-1:0]     mac_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PSUM_BW-1:0]     out_data,
  output logic                   busy
);

  localparam int unsigned LaneW = NumLanes * BW;
  localparam int unsigned LatW  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  state_e               state_q, state_d;
  logic [PSUM_BW-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d, len_q, len_d;
  logic [LatW-1:0]      lat_q, lat_d;
  logic                 rdy_q;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty, issue;
  logic [2*LaneW-1:0]   head;

  assign in_ready  = rdy_q && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign issue     = (state_q == StIssue);

  mac_seq_fifo #(
    .Width (2 * LaneW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   ({in_b, in_a}),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Operands are only driven during the single ISSUE cycle.
  always_comb begin
    a0    = issue ? head[0*BW +: BW]         : '0;
    a1    = issue ? head[1*BW +: BW]         : '0;
    a2    = issue ? head[2*BW +: BW]         : '0;
    a3    = issue ? head[3*BW +: BW]         : '0;
    b0    = issue ? head[LaneW + 0*BW +: BW] : '0;
    b1    = issue ? head[LaneW + 1*BW +: BW] : '0;
    b2    = issue ? head[LaneW + 2*BW +: BW] : '0;
    b3    = issue ? head[LaneW + 3*BW +: BW] : '0;
    mac_c = issue ? acc_q                    : '0;
  end

`ifdef MAC_SEQ_RELU_EN
  assign out_data = acc_q[PSUM_BW-1] ? '0 : acc_q;
`else
  assign out_data = acc_q;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    lat_d     = lat_q;
    fifo_pop  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StIssue;
          // A new result starts only when no groups are accumulated yet.
          if (cnt_q == '0) len_d = (len == '0) ? LEN_W'(1) : len;
        end
      end
      StIssue: begin
        fifo_pop = 1'b1;
        lat_d    = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (lat_q == LatW'(MAC_LAT - 1)) begin
          acc_d = mac_out;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q)   state_d = StDone;
          else if (!fifo_empty) state_d = StIssue;
          else                  state_d = StIdle;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      lat_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      lat_q   <= lat_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule
